// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the single-cycle RISC-V core. It owns the program counter and
// fetches one 32-bit instruction at a time from instruction memory over a
// req/ack handshake. The fetched word is held for decode until the core
// retires it. The PC then advances by 4, or is redirected to the branch/jump
// target when pc_src is set.
//
// Sequence: IDLE (one cycle after reset) -> REQ (wait for ack) -> HOLD (wait
// for core_ready) -> REQ ...  At most one instruction per two cycles.
//
// Optional build macro:
//   MISALIGN_TRAP_EN  When defined, a taken redirect to a target with
//                     pc_target[1:0] != 0 enters a FAULT state. FAULT asserts
//                     fetch_fault, stops fetching, and is left only by reset.
//                     When undefined, the low two target bits are silently
//                     cleared and fetch_fault is tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   fetch request (held until ack) and address (= pc)
//   imem_ack, imem_rdata  memory response, data valid when ack=1
//   instr, instr_valid    registered instruction and its valid flag
//   pc, pc_plus4          address of instr and pc+4 (wraps modulo 2^XLEN)
//   core_ready            core retires instr this cycle (used only in HOLD)
//   pc_src, pc_target     redirect select and target, sampled with core_ready
//   fetch_fault           misaligned-target fault (see macro above)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            core_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault
);

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
`endif

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_p0, pc_nxt;
    logic [XLEN-1:0] instr_p0, instr_nxt;

    // PC value loaded on a taken redirect.
    function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] tgt);
`ifdef MISALIGN_TRAP_EN
        // Misaligned targets are loaded as-is so the faulting address is visible on pc.
        return tgt;
`else
        return tgt & ~XLEN'(3);
`endif
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [XLEN-1:0] tgt);
        return |tgt[1:0];
    endfunction
`endif

    // Stage p0: fetch state, PC and captured instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_p0    <= RESET_PC;
            instr_p0 <= NOP_INSTR;
        end else begin
            state    <= state_nxt;
            pc_p0    <= pc_nxt;
            instr_p0 <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        instr_nxt = instr_p0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (core_ready) begin
                    if (pc_src) begin
                        pc_nxt    = redirect_pc(pc_target);
                        state_nxt = REQ;
`ifdef MISALIGN_TRAP_EN
                        if (is_misaligned(pc_target)) begin
                            state_nxt = FAULT;
                        end
`endif
                    end else begin
                        pc_nxt    = pc_plus4;
                        state_nxt = REQ;
                    end
                end
            end
`ifdef MISALIGN_TRAP_EN
            FAULT: state_nxt = FAULT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode directly from state so reset drops imem_req without a clock edge.
    assign imem_req    = (state == REQ);
    assign imem_addr   = pc_p0;
    assign instr       = instr_p0;
    assign instr_valid = (state == HOLD);
    assign pc          = pc_p0;
    assign pc_plus4    = pc_p0 + XLEN'(4);
`ifdef MISALIGN_TRAP_EN
    assign fetch_fault = (state == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        core_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .core_ready (core_ready),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .fetch_fault(fetch_fault)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int unsigned lat;   // idle REQ cycles before ack
        logic [31:0] word;  // instruction returned by memory
        logic        src;   // pc_src at accept
        logic [31:0] tgt;   // pc_target at accept
        logic [31:0] addr;  // expected fetch address of this row
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DUT is in REQ at address a; memory answers after lat idle cycles.
    task automatic fetch(input string tag, input int unsigned lat, input logic [31:0] a,
                         input logic [31:0] w, input bit junk);
        for (int i = 0; i <= int'(lat); i++) begin
            chk({tag, " req"}, 32'(imem_req), 32'd1);
            chk({tag, " addr"}, imem_addr, a);
            chk({tag, " valid_low"}, 32'(instr_valid), 32'd0);
            core_ready = junk ? 1'($urandom) : 1'b0;
            pc_src     = 1'($urandom);
            pc_target  = $urandom;
            imem_ack   = (i == int'(lat));
            imem_rdata = (i == int'(lat)) ? w : (32'hBAD0_0000 | 32'(i));
            step();
        end
        imem_ack   = 1'b0;
        core_ready = 1'b0;
        chk({tag, " instr"}, instr, w);
        chk({tag, " valid"}, 32'(instr_valid), 32'd1);
        chk({tag, " pc"}, pc, a);
        chk({tag, " pc_plus4"}, pc_plus4, a + 32'd4);
        chk({tag, " req_low"}, 32'(imem_req), 32'd0);
        chk({tag, " fault"}, 32'(fetch_fault), 32'd0);
    endtask

    // Stay in HOLD for n cycles, optionally with a stray ack carrying other data.
    task automatic hold(input string tag, input int unsigned n, input bit stray,
                        input logic [31:0] w, input logic [31:0] a);
        for (int i = 0; i < int'(n); i++) begin
            core_ready = 1'b0;
            pc_src     = 1'($urandom);
            pc_target  = $urandom;
            imem_ack   = stray;
            imem_rdata = ~w;
            step();
            chk({tag, " hold_instr"}, instr, w);
            chk({tag, " hold_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, " hold_pc"}, pc, a);
            chk({tag, " hold_req"}, 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    task automatic accept(input logic src, input logic [31:0] tgt);
        core_ready = 1'b1;
        pc_src     = src;
        pc_target  = tgt;
        step();
        core_ready = 1'b0;
        pc_src     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mpc;
        logic [31:0] w;
        logic [31:0] tgt;
        logic        src;

        tbl[0] = '{1, 32'h0050_0093, 1'b0, 32'h0,         32'h0};
        tbl[1] = '{0, 32'h0010_0113, 1'b1, 32'h10,        32'h4};
        tbl[2] = '{0, 32'h0020_81b3, 1'b0, 32'h0,         32'h10};
        tbl[3] = '{0, 32'h0000_006f, 1'b1, 32'h40,        32'h14};
        tbl[4] = '{5, 32'hfe00_0ee3, 1'b1, 32'hFFFF_FFFC, 32'h40};
        tbl[5] = '{2, 32'h0000_0013, 1'b0, 32'h0,         32'hFFFF_FFFC};
        tbl[6] = '{0, 32'h1234_5678, 1'b0, 32'h0,         32'h0};

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst pc", pc, RST_PC);
        chk("rst instr", instr, NOP);
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst fault", 32'(fetch_fault), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        chk("idle req", 32'(imem_req), 32'd0);
        // Late ack during IDLE must not be captured.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("idle ack ignored", instr, NOP);

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            fetch(tag, tbl[i].lat, tbl[i].addr, tbl[i].word, 1'b0);
            hold(tag, 2, 1'b1, tbl[i].word, tbl[i].addr);
            accept(tbl[i].src, tbl[i].tgt);
        end

        // Randomized traffic against the PC model.
        mpc = 32'h4;
        for (int k = 0; k < 40; k++) begin
            string tag;
            tag = $sformatf("rnd%0d", k);
            w = $urandom;
            fetch(tag, $urandom_range(0, 3), mpc, w, 1'b1);
            hold(tag, $urandom_range(0, 2), 1'($urandom), w, mpc);
            src = 1'($urandom);
            tgt = $urandom;
`ifdef MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            accept(src, tgt);
            mpc = src ? {tgt[31:2], 2'b00} : mpc + 32'd4;
        end

        // Reset pulled mid-REQ takes effect without a clock edge.
        chk("pre-reset req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst req", 32'(imem_req), 32'd0);
        chk("async rst pc", pc, RST_PC);
        chk("async rst instr", instr, NOP);
        chk("async rst valid", 32'(instr_valid), 32'd0);
        step();
        rst_n = 1'b1;
        chk("reidle req", 32'(imem_req), 32'd0);
        step();
        fetch("post-rst", 0, RST_PC, 32'h0000_0533, 1'b0);

        // Taken redirect to a misaligned target.
        accept(1'b1, 32'h42);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            chk("trap fault", 32'(fetch_fault), 32'd1);
            chk("trap pc", pc, 32'h42);
            chk("trap req", 32'(imem_req), 32'd0);
            chk("trap valid", 32'(instr_valid), 32'd0);
            core_ready = 1'b1;
            imem_ack   = 1'b1;
            step();
        end
        core_ready = 1'b0;
        imem_ack   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("trap cleared", 32'(fetch_fault), 32'd0);
        chk("trap rst pc", pc, RST_PC);
        rst_n = 1'b1;
`else
        chk("mis fault", 32'(fetch_fault), 32'd0);
        chk("mis req", 32'(imem_req), 32'd1);
        chk("mis addr", imem_addr, 32'h40);
        fetch("mis", 0, 32'h40, 32'h0000_0073, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the single-cycle RISC-V core.
- Owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction with a valid flag to the decode/control stage.
- On accept, advances PC by 4 or redirects to the branch/jump target, selected by the core's PcSrc.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC and instruction width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  XLEN  fetch address, equals pc while imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- instr  out  XLEN  registered instruction to decode/controller.
- instr_valid  out  1  instr/pc/pc_plus4 hold a fetched instruction.
- pc  out  XLEN  address of instr.
- pc_plus4  out  XLEN  pc+4, combinational from pc.
- core_ready  in  1  core retires instr this cycle.
- pc_src  in  1  PcSrc from controller, sampled with core_ready.
- pc_target  in  XLEN  branch/jump target, sampled with core_ready.
- fetch_fault  out  1  misaligned-target fault (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_fault=0.
  - State=IDLE.
  - Any outstanding request is abandoned; a late ack after reset release is ignored unless the state is REQ.
- IDLE: lasts one cycle after rst_n rises, then REQ. imem_req=0.
- REQ:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - imem_ack=1 (same-cycle ack allowed): instr<=imem_rdata, instr_valid<=1, go HOLD.
  - Minimum fetch latency is 1 cycle from imem_req rising to instr_valid=1.
- HOLD:
  - imem_req=0; instr, pc and instr_valid stay stable while core_ready=0.
  - On core_ready=1: pc<=(pc_src ? pc_target : pc+4), instr_valid<=0, go REQ.
  - imem_ack in HOLD or IDLE is ignored; rdata is not captured.
- Throughput: at most one instruction per 2 cycles (REQ, HOLD). A fetch never overlaps decode.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No carry out is reported.
- core_ready or pc_src outside HOLD is ignored.
- pc_target is used only when pc_src=1 at the accept edge.
- Reset asserted in any state returns to reset values within the same cycle (asynchronous). imem_req drops immediately.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On accept with pc_src=1 and pc_target[1:0]!=0, go to FAULT instead of REQ.
  - In FAULT: pc<=pc_target (unmodified), fetch_fault=1, imem_req=0, instr_valid=0.
  - FAULT is left only by reset.
- Not defined:
  - fetch_fault tied 0; the FAULT state is not built.
  - Redirect loads {pc_target[31:2],2'b00}, i.e. the low bits are silently cleared.

Test Plan:
- Reset release, RESET_PC=0, memory acks next cycle with 32'h00500093 -> imem_req=1 with addr 0; after ack instr=32'h00500093, instr_valid=1, pc=0, pc_plus4=4.
- Sequential: core_ready=1 with pc_src=0 at pc=0x10 -> next imem_addr=0x14; instr_valid low for exactly one cycle when ack is same-cycle.
- Branch taken: pc_src=1, pc_target=0x40 at accept -> next imem_addr=0x40; pc=0x40 when instr_valid rises.
- Memory wait states: ack delayed 5 cycles -> imem_req and imem_addr=pc held constant all 5 cycles; a stray ack in HOLD leaves instr unchanged.
- Wrap and reset:
  - pc=0xFFFFFFFC, sequential accept -> next imem_addr=0.
  - rst_n pulled low mid-REQ -> imem_req=0 and pc=RESET_PC immediately, with no clock edge needed.
- Misalign, pc_target=0x42, pc_src=1:
  - With MISALIGN_TRAP_EN: fetch_fault=1, pc=0x42, no further imem_req until reset.
  - Without it: next imem_addr=0x40, fetch_fault=0.
